pnm_cmd_dispatcher: RTL and testbench
=====================================

// Module: pnm_cmd_dispatcher
// PURPOSE
//  Queued, parametrised PNM command controller. Accepts scheduler commands {op, start, end, result} into a FIFO.
//  Dispatches one at a time to NUM_ENGINES near-memory engines (ReLU / MaxPool / Move) once every PIM page
//  the command touches reports ready. Sits between the scheduler and the PNM engines; unlike a single-latch
//  controller it buffers, rejects illegal ops/ranges, and tracks per-command completion.
// PARAMETERS
//  DATA_WIDTH    32  datapath width (passed through to engines; unused internally)
//  Address_Size  16  address width
//  NUM_PIMS      32  PIM page count (power of 2); page index = addr[Address_Size-1 -: $clog2(NUM_PIMS)]
//  FIFO_DEPTH    8   command queue depth (power of 2, >=2)
//  NUM_ENGINES   3   engine count; opcode->index map in pnm_pkg
// PORTS
//  clk              in   1             clock
//  rst_n            in   1             async active-low reset
//  cmd_valid        in   1             scheduler offers command
//  cmd_ready        out  1             = !fifo_full; push on cmd_valid&cmd_ready
//  cmd_op           in   6             opcode
//  cmd_start_addr   in   Address_Size  source start
//  cmd_end_addr     in   Address_Size  source end (inclusive)
//  cmd_result_addr  in   Address_Size  destination start
//  pim_ready        in   NUM_PIMS      per-page ready
//  eng_start        out  NUM_ENGINES   1-cycle start pulse, one-hot
//  eng_en           out  NUM_ENGINES   held enable of active engine, one-hot
//  eng_done         in   NUM_ENGINES   engine completion
//  act_start_addr / act_end_addr / act_result_addr  out  Address_Size  active command addresses
//  busy             out  1             state != IDLE
//  done             out  1             1-cycle pulse per completed command
//  err_illegal      out  1             1-cycle pulse per dropped command
//  fifo_level       out  $clog2(FIFO_DEPTH)+1  queued entries
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0 except cmd_ready=1; FIFO empty; state IDLE; act_* = 0.
//  Opcodes: RELU=6'b010111->idx0, MAX_POOL=6'b110011->idx1, MOVE=6'b110111->idx2; others illegal.
//  FSM:
//   IDLE: if FIFO non-empty, pop and latch act_*/op.
//         If op illegal or end<start: err_illegal pulse, stay IDLE, entry discarded.
//         Else -> WAIT_RDY.
//   WAIT_RDY: ready_eval = AND over pages p in [pg(start),pg(end)] U [pg(result),pg(res_end)] of pim_ready[p].
//         res_end = result + (end-start), computed mod 2^Address_Size.
//         Untouched pages are don't-care. When ready_eval: eng_start[sel]=1 for exactly this cycle -> BUSY.
//   BUSY: eng_en[sel]=1. On eng_done[sel]: done pulse next edge, -> IDLE. eng_done of other engines ignored.
//  Latency: push at edge t is poppable at t+1. Ready pages give eng_start at t+2.
//   Min throughput one command per 3 cycles + engine time.
//  FIFO: push when full is refused (cmd_ready=0). Simultaneous push+pop when full: pop frees, push refused that cycle.
//   Simultaneous push+pop when empty: new entry held, not bypassed. Pointers wrap mod FIFO_DEPTH; level exact.
//  pim_ready dropping in BUSY: no effect (checked only in WAIT_RDY).
//  Reset mid-operation: immediate abort; queued commands lost; no done pulse.
// STRUCTURE
//  pnm_pkg: opcode localparams, op->engine index function, page_of() helper.
//  Sub-module pnm_cmd_fifo: sync FIFO, width 6+3*Address_Size, async-reset pointers. FSM and mask logic stay in top.
// TESTING
//  1 Push RELU s=0x0000 e=0x07FF r=0x8000, all ready:
//    eng_start[0] pulse 2 cycles after push; eng_done[0] -> done pulse; busy low after.
//  2 Same cmd with pim_ready[16]=0: stalls in WAIT_RDY. Raise bit 16 -> eng_start[0] next cycle.
//    Toggling unrelated page 5 has no effect.
//  3 Push 9 commands back-to-back with engine stalled: cmd_ready low after 8, fifo_level=8.
//    Complete one -> ready returns; all 9 dispatched in order.
//  4 Op 6'b000001, then MOVE with e<s: two err_illegal pulses, no eng_start. Following valid MAX_POOL runs on eng[1].
//  5 res_end wraps (r=0xFC00, e-s=0x07FF): pages 31 and 0..(wrapped) gate correctly; no X on addresses.
//  6 Assert rst_n=0 in BUSY with 3 queued: all outputs reset at once, fifo_level=0, no done pulse.

Source files
------------

// File: rtl/pnm_pkg.sv
// Shared opcodes, FSM states and address/page helpers for the PNM command dispatcher.
// Latency: n/a (pure definitions); backpressure: n/a.
package pnm_pkg;

    localparam logic [5:0] OP_RELU     = 6'b010111;
    localparam logic [5:0] OP_MAX_POOL = 6'b110011;
    localparam logic [5:0] OP_MOVE     = 6'b110111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_BUSY     = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RELU) || (op == OP_MAX_POOL) || (op == OP_MOVE);
    endfunction

    function automatic logic [1:0] op_to_eng(input logic [5:0] op);
        case (op)
            OP_MAX_POOL: return 2'd1;
            OP_MOVE:     return 2'd2;
            default:     return 2'd0;
        endcase
    endfunction

    // Page index is the top pw bits of an aw-bit address.
    function automatic int page_of(input logic [31:0] addr, input int aw, input int pw);
        logic [31:0] pg;
        pg = (addr >> (aw - pw)) & ((32'd1 << pw) - 32'd1);
        return int'(pg);
    endfunction

endpackage

// File: rtl/pnm_cmd_fifo.sv
// Synchronous command FIFO; an entry pushed at edge t is visible on rd_dat after t (poppable at t+1).
// Latency: 1 cycle write-to-read, no bypass; backpressure: wr_rdy low when full, a same-cycle pop does not free it.
module pnm_cmd_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   wr_rdy,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_dat,
    output logic                   rd_vld,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;
    logic             push, pop;

    assign wr_rdy = (level_q != (PW+1)'(DEPTH));
    assign rd_vld = (level_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = level_q;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && rd_vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (PW+1)'(push) - (PW+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/pnm_cmd_dispatcher.sv
// Queued PNM command dispatcher: validates each command, waits for every touched PIM page, runs one engine at a time.
// Latency: push at t -> eng_start at t+2 when pages ready; backpressure: cmd_ready = FIFO not full.
module pnm_cmd_dispatcher
    import pnm_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int Address_Size = 16,
    parameter int NUM_PIMS     = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int NUM_ENGINES  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_op,
    input  logic [Address_Size-1:0]       cmd_start_addr,
    input  logic [Address_Size-1:0]       cmd_end_addr,
    input  logic [Address_Size-1:0]       cmd_result_addr,
    input  logic [NUM_PIMS-1:0]           pim_ready,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [NUM_ENGINES-1:0]        eng_en,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    output logic [Address_Size-1:0]       act_start_addr,
    output logic [Address_Size-1:0]       act_end_addr,
    output logic [Address_Size-1:0]       act_result_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          err_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = Address_Size;
    localparam int PW = $clog2(NUM_PIMS);
    localparam int EW = 6 + 3 * AW;

    if (DATA_WIDTH < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (NUM_PIMS & (NUM_PIMS - 1)) != 0 || NUM_ENGINES > 4) begin : g_param_chk
        $error("pnm_cmd_dispatcher: unsupported parameter set");
    end

    state_t                state_q, state_d;
    logic [AW-1:0]         act_start_q, act_start_d;
    logic [AW-1:0]         act_end_q, act_end_d;
    logic [AW-1:0]         act_result_q, act_result_d;
    logic [1:0]            sel_q, sel_d;
    logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [EW-1:0]         head;
    logic                  fifo_rd_vld, fifo_pop;
    logic [5:0]            h_op;
    logic [AW-1:0]         h_start, h_end, h_result;
    logic [NUM_ENGINES-1:0] sel_oh;
    logic [AW-1:0]         res_end;
    logic                  res_wrap;
    int                    pg_s, pg_e, pg_r, pg_re;
    logic [NUM_PIMS-1:0]   page_mask;
    logic                  ready_eval;

    pnm_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (cmd_valid),
        .wr_dat ({cmd_op, cmd_start_addr, cmd_end_addr, cmd_result_addr}),
        .wr_rdy (cmd_ready),
        .rd_en  (fifo_pop),
        .rd_dat (head),
        .rd_vld (fifo_rd_vld),
        .level  (fifo_level)
    );

    assign h_op     = head[EW-1 -: 6];
    assign h_start  = head[3*AW-1 -: AW];
    assign h_end    = head[2*AW-1 -: AW];
    assign h_result = head[AW-1:0];

    assign sel_oh = NUM_ENGINES'(1) << sel_q;

    // Destination span may wrap past the top of the address space.
    assign res_end  = act_result_q + (act_end_q - act_start_q);
    assign res_wrap = (res_end < act_result_q);
    assign pg_s     = page_of(32'(act_start_q), AW, PW);
    assign pg_e     = page_of(32'(act_end_q), AW, PW);
    assign pg_r     = page_of(32'(act_result_q), AW, PW);
    assign pg_re    = page_of(32'(res_end), AW, PW);

    always_comb begin
        page_mask = '0;
        for (int p = 0; p < NUM_PIMS; p++) begin
            page_mask[p] = (p >= pg_s && p <= pg_e) ||
                           (res_wrap ? (p >= pg_r || p <= pg_re) : (p >= pg_r && p <= pg_re));
        end
    end

    assign ready_eval = &(pim_ready | ~page_mask);

    always_comb begin
        state_d      = state_q;
        act_start_d  = act_start_q;
        act_end_d    = act_end_q;
        act_result_d = act_result_q;
        sel_d        = sel_q;
        eng_start_d  = '0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_vld) begin
                    fifo_pop     = 1'b1;
                    act_start_d  = h_start;
                    act_end_d    = h_end;
                    act_result_d = h_result;
                    sel_d        = op_to_eng(h_op);
                    if (!op_legal(h_op) || (h_end < h_start)) err_d = 1'b1;
                    else                                       state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (ready_eval) begin
                    eng_start_d = sel_oh;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (|(eng_done & sel_oh)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            act_start_q  <= '0;
            act_end_q    <= '0;
            act_result_q <= '0;
            sel_q        <= '0;
            eng_start_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_start_q  <= act_start_d;
            act_end_q    <= act_end_d;
            act_result_q <= act_result_d;
            sel_q        <= sel_d;
            eng_start_q  <= eng_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign eng_start       = eng_start_q;
    assign eng_en          = (state_q == ST_BUSY) ? sel_oh : '0;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign err_illegal     = err_q;
    assign act_start_addr  = act_start_q;
    assign act_end_addr    = act_end_q;
    assign act_result_addr = act_result_q;

endmodule

// File: tb/tb_pnm_cmd_dispatcher.sv
// Scoreboard bench for pnm_cmd_dispatcher: stimulus queues expected start/done/error events, a monitor pops them.
`timescale 1ns/1ps
module tb_pnm_cmd_dispatcher;
    import pnm_pkg::*;

    localparam int AW = 16;
    localparam int NP = 32;
    localparam int FD = 8;
    localparam int NE = 3;
    localparam int LW = 4;
    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int ENG_LAT = 3;

    typedef struct {
        int            kind;
        int            eng;
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        logic [AW-1:0] r;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [5:0]    cmd_op = '0;
    logic [AW-1:0] cmd_start_addr = '0;
    logic [AW-1:0] cmd_end_addr = '0;
    logic [AW-1:0] cmd_result_addr = '0;
    logic [NP-1:0] pim_ready = '1;
    logic [NE-1:0] eng_start, eng_en;
    logic [NE-1:0] eng_done = '0;
    logic [AW-1:0] act_start_addr, act_end_addr, act_result_addr;
    logic          busy, done, err_illegal;
    logic [LW-1:0] fifo_level;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   eng_hold = 1'b0;
    int   eng_cnt = 0;

    pnm_cmd_dispatcher #(
        .DATA_WIDTH(32), .Address_Size(AW), .NUM_PIMS(NP), .FIFO_DEPTH(FD), .NUM_ENGINES(NE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr), .cmd_result_addr(cmd_result_addr),
        .pim_ready(pim_ready), .eng_start(eng_start), .eng_en(eng_en), .eng_done(eng_done),
        .act_start_addr(act_start_addr), .act_end_addr(act_end_addr), .act_result_addr(act_result_addr),
        .busy(busy), .done(done), .err_illegal(err_illegal), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_run(input int eng, input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [AW-1:0] r);
        exp_q.push_back('{kind: K_START, eng: eng, s: s, e: e, r: r});
        exp_q.push_back('{kind: K_DONE, eng: eng, s: s, e: e, r: r});
    endtask

    task automatic exp_err();
        exp_q.push_back('{kind: K_ERR, eng: 0, s: '0, e: '0, r: '0});
    endtask

    task automatic check_event(input int kind);
        exp_t          ex;
        logic [NE-1:0] oh;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got kind %0d, expected no event", kind);
            return;
        end
        ex = exp_q.pop_front();
        if (ex.kind != kind) begin
            n_err++;
            $display("FAIL event_kind: got kind %0d, expected kind %0d", kind, ex.kind);
            return;
        end
        if (kind == K_START) begin
            oh = NE'(1) << ex.eng;
            if (eng_start !== oh || eng_en !== oh || act_start_addr !== ex.s ||
                act_end_addr !== ex.e || act_result_addr !== ex.r) begin
                n_err++;
                $display("FAIL start_event: got start=%b en=%b s=%h e=%h r=%h, expected start=en=%b s=%h e=%h r=%h",
                         eng_start, eng_en, act_start_addr, act_end_addr, act_result_addr, oh, ex.s, ex.e, ex.r);
            end
        end else if (kind == K_DONE) begin
            if (eng_en !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL done_event: got en=%b busy=%b, expected en=0 busy=0", eng_en, busy);
            end
        end
    endtask

    // Monitor: every start, error or done pulse must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start != '0) check_event(K_START);
            if (err_illegal)     check_event(K_ERR);
            if (done)            check_event(K_DONE);
        end
    end

    // Engine model: completes ENG_LAT+1 cycles after enable unless held.
    initial begin
        forever begin
            @(negedge clk);
            eng_done = '0;
            if (eng_en != '0 && !eng_hold && rst_n) begin
                if (eng_cnt == ENG_LAT) begin
                    eng_done = eng_en;
                    eng_cnt  = 0;
                end else begin
                    eng_cnt++;
                end
            end else begin
                eng_cnt = 0;
            end
        end
    end

    task automatic push_cmd(input logic [5:0] op, input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [AW-1:0] r);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_start_addr = s; cmd_end_addr = e; cmd_result_addr = r;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: got cmd_ready=0 for 200 cycles, expected 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || fifo_level != '0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(busy || fifo_level != '0), 64'd0);
    endtask

    logic [5:0] ops [3];

    initial begin
        ops[0] = OP_RELU; ops[1] = OP_MAX_POOL; ops[2] = OP_MOVE;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 64'({eng_start, eng_en, busy, done, err_illegal, fifo_level}), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_act", 64'({act_start_addr, act_end_addr, act_result_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic RELU, all pages ready, two-cycle dispatch latency
        exp_run(0, 16'h0000, 16'h07FF, 16'h8000);
        push_cmd(OP_RELU, 16'h0000, 16'h07FF, 16'h8000);
        @(posedge clk); #1;
        check("t1_lat1_start", 64'(eng_start), 64'd0);
        check("t1_lat1_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t1_lat2_start", 64'(eng_start), 64'b001);
        @(posedge clk); #1;
        check("t1_pulse_len", 64'({eng_start, eng_en}), 64'b000_001);
        wait_idle("t1_idle");

        // 2: page 16 gates the destination; page 5 is untouched
        @(negedge clk);
        pim_ready[16] = 1'b0;
        exp_run(0, 16'h0000, 16'h07FF, 16'h8000);
        push_cmd(OP_RELU, 16'h0000, 16'h07FF, 16'h8000);
        repeat (5) @(posedge clk);
        #1;
        check("t2_stall", 64'({eng_start, eng_en, busy}), 64'b000_000_1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pim_ready[5] = ~pim_ready[5];
            @(posedge clk); #1;
            check("t2_page5_no_effect", 64'(eng_start), 64'd0);
        end
        @(negedge clk);
        pim_ready[16] = 1'b1;
        @(posedge clk); #1;
        check("t2_release_start", 64'(eng_start), 64'b001);
        wait_idle("t2_idle");

        // 3: fill the queue behind a stalled engine, then drain in order
        @(negedge clk);
        eng_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_run(i % 3, 16'(i * 256), 16'(i * 256 + 255), 16'(32768 + i * 256));
            push_cmd(ops[i % 3], 16'(i * 256), 16'(i * 256 + 255), 16'(32768 + i * 256));
        end
        check("t3_full_level", 64'(fifo_level), 64'd8);
        check("t3_full_ready", 64'(cmd_ready), 64'd0);
        check("t3_first_active", 64'(eng_en), 64'b001);
        exp_run(0, 16'h0900, 16'h09FF, 16'h8900);
        fork
            push_cmd(OP_RELU, 16'h0900, 16'h09FF, 16'h8900);
            begin
                repeat (4) @(negedge clk);
                check("t3_full_refuse", 64'(fifo_level), 64'd8);
                eng_hold = 1'b0;
            end
        join
        check("t3_refill_level", 64'(fifo_level), 64'd8);
        wait_idle("t3_drain");

        // 4: illegal opcode and reversed range are dropped; next command runs on engine 1
        exp_err();
        push_cmd(6'b000001, 16'h0000, 16'h0100, 16'h4000);
        @(posedge clk); #1;
        check("t4_err_pulse", 64'({err_illegal, busy}), 64'b10);
        exp_err();
        push_cmd(OP_MOVE, 16'h3000, 16'h2000, 16'h5000);
        exp_run(1, 16'h1000, 16'h10FF, 16'h6000);
        push_cmd(OP_MAX_POOL, 16'h1000, 16'h10FF, 16'h6000);
        wait_idle("t4_idle");

        // 5: destination wraps past 0xFFFF, touching pages 31 and 0
        @(negedge clk);
        pim_ready[0] = 1'b0;
        exp_run(2, 16'h2000, 16'h27FF, 16'hFC00);
        push_cmd(OP_MOVE, 16'h2000, 16'h27FF, 16'hFC00);
        repeat (4) @(posedge clk);
        #1;
        check("t5_stall_pg0", 64'({eng_start, busy}), 64'b000_1);
        check("t5_no_x", 64'($isunknown({act_start_addr, act_end_addr, act_result_addr})), 64'd0);
        check("t5_act_result", 64'(act_result_addr), 64'hFC00);
        @(negedge clk);
        pim_ready[0] = 1'b1; pim_ready[31] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_stall_pg31", 64'(eng_start), 64'd0);
        @(negedge clk);
        pim_ready[31] = 1'b1; pim_ready[1] = 1'b0;
        @(posedge clk); #1;
        check("t5_start", 64'(eng_start), 64'b100);
        @(negedge clk);
        pim_ready = '0;
        wait_idle("t5_busy_ignores_ready");
        @(negedge clk);
        pim_ready = '1;

        // 6: reset while busy with queued work aborts everything
        eng_hold = 1'b1;
        exp_q.push_back('{kind: K_START, eng: 2, s: 16'h0100, e: 16'h01FF, r: 16'h0400});
        push_cmd(OP_MOVE, 16'h0100, 16'h01FF, 16'h0400);
        for (int i = 0; i < 3; i++) push_cmd(OP_RELU, 16'(i * 16), 16'(i * 16 + 15), 16'h0800);
        @(posedge clk); #1;
        check("t6_pre_level", 64'({busy, fifo_level}), 64'({1'b1, 4'd3}));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", 64'({eng_start, eng_en, busy, done, err_illegal, fifo_level}), 64'd0);
        check("t6_rst_ready", 64'(cmd_ready), 64'd1);
        check("t6_rst_act", 64'({act_start_addr, act_end_addr, act_result_addr}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        eng_hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_post_idle", 64'({busy, fifo_level}), 64'd0);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
